// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants for the UART receive path: FSM state
//                encoding, parity mode codes and a ceil-log2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states, 3-bit encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Parity mode codes for PARITY_MODE
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Ceiling log2, minimum result 0; used for counter widths
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = value - 1; i > 0; i = i >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchroniser for an asynchronous serial line.
//                Resets to 1 so an idle line never looks like a start edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic iClk,
    input  logic iRst_n,
    input  logic iAsync,
    output logic oSync
);

    logic [1:0] r_sync;

    // Two-stage metastability filter, idle-high reset value
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], iAsync};
        end
    end

    assign oSync = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parametrised UART receiver driven by an oversample tick.
//                Configurable data width, oversampling, parity and stop
//                bits; start-glitch rejection; parity and framing errors.
//                Optional macro UART_RX_MAJORITY_EN: each bit decision is a
//                2-of-3 vote over the centre tick and the two ticks before.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iB_Tick,
    input  logic                 iRx,
    output logic [DATA_BITS-1:0] oRx_Data,
    output logic                 oRx_Valid,
    output logic                 oRx_Busy,
    output logic                 oParity_Err,
    output logic                 oFrame_Err
);

    localparam int c_CNT_W = clog2(OVERSAMPLE);
    localparam int c_BIT_W = clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);

    logic                 w_rxS;
    logic                 r_rxPrev;
    logic [2:0]           r_state;
    logic [2:0]           w_stateNext;
    logic [c_CNT_W-1:0]   r_tickCnt;
    logic [c_BIT_W-1:0]   r_bitCnt;
    logic                 r_stopCnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parErr;
    logic                 r_frmErr;
    logic                 w_bitVal;
    logic                 w_atMid;
    logic                 w_atCentre;
    logic                 w_stopLast;

    uart_rx_sync u_sync (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iAsync (iRx),
        .oSync  (w_rxS)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keep the two most recent tick samples for the 2-of-3 vote
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_hist <= 2'b11;
        end else if (iB_Tick) begin
            r_hist <= {r_hist[0], w_rxS};
        end
    end

    assign w_bitVal = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxS) | (r_hist[0] & w_rxS);
`else
    assign w_bitVal = w_rxS;
`endif

    assign w_atMid    = iB_Tick && (r_tickCnt == c_CNT_MID);
    assign w_atCentre = iB_Tick && (r_tickCnt == c_CNT_LAST);
    assign w_stopLast = (STOP_BITS == 1) ? 1'b1 : r_stopCnt;
    assign oRx_Busy   = (r_state != ST_IDLE);

    // Next-state decode; transitions only on sample ticks or a start edge
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_rxPrev && !w_rxS) w_stateNext = ST_START;
            end
            ST_START: begin
                if (w_atMid) w_stateNext = w_bitVal ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_atCentre && (r_bitCnt == c_BIT_LAST))
                    w_stateNext = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_atCentre) w_stateNext = ST_STOP;
            end
            ST_STOP: begin
                if (w_atCentre && w_stopLast) w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // State register, counters, shift register and output registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state     <= ST_IDLE;
            r_rxPrev    <= 1'b1;
            r_tickCnt   <= '0;
            r_bitCnt    <= '0;
            r_stopCnt   <= 1'b0;
            r_shift     <= '0;
            r_parErr    <= 1'b0;
            r_frmErr    <= 1'b0;
            oRx_Data    <= '0;
            oRx_Valid   <= 1'b0;
            oParity_Err <= 1'b0;
            oFrame_Err  <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_rxPrev  <= w_rxS;
            oRx_Valid <= 1'b0;

            // Tick counter restarts with every state so each phase is timed
            // from its own entry point.
            if (w_stateNext != r_state) begin
                r_tickCnt <= '0;
            end else if (iB_Tick) begin
                r_tickCnt <= (r_tickCnt == c_CNT_LAST) ? '0 : r_tickCnt + 1'b1;
            end

            case (r_state)
                ST_START: begin
                    r_bitCnt  <= '0;
                    r_stopCnt <= 1'b0;
                    r_parErr  <= 1'b0;
                    r_frmErr  <= 1'b0;
                end
                ST_DATA: begin
                    if (w_atCentre) begin
                        r_shift  <= {w_bitVal, r_shift[DATA_BITS-1:1]};
                        r_bitCnt <= r_bitCnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_atCentre)
                        r_parErr <= ((^r_shift) ^ w_bitVal) != (PARITY_MODE == PARITY_ODD);
                end
                ST_STOP: begin
                    if (w_atCentre) begin
                        r_stopCnt <= 1'b1;
                        if (!w_bitVal) r_frmErr <= 1'b1;
                        if (w_stopLast) begin
                            oRx_Valid   <= 1'b1;
                            oRx_Data    <= r_shift;
                            oParity_Err <= r_parErr;
                            oFrame_Err  <= r_frmErr | ~w_bitVal;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Directed self-checking bench for uart_rx_param. Three
//                instances: 8N1/OS16, 8E2/OS16 and 5N1/OS8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    logic       iClk    = 1'b0;
    logic       iRst_n  = 1'b0;
    logic       bTick   = 1'b0;
    logic [1:0] tickDiv = 2'd0;
    logic       rxA = 1'b1, rxB = 1'b1, rxC = 1'b1;

    logic [7:0] dataA, dataB;
    logic [4:0] dataC;
    logic       validA, busyA, perrA, ferrA;
    logic       validB, busyB, perrB, ferrB;
    logic       validC, busyC, perrC, ferrC;

    int nAssert = 0;
    int nFail   = 0;

    int         cnt[3] = '{0, 0, 0};
    logic [8:0] lastD[3];
    logic       lastP[3];
    logic       lastF[3];
    logic [4:0] logC[8];

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_dutA (
        .iClk(iClk), .iRst_n(iRst_n), .iB_Tick(bTick), .iRx(rxA),
        .oRx_Data(dataA), .oRx_Valid(validA), .oRx_Busy(busyA),
        .oParity_Err(perrA), .oFrame_Err(ferrA));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(2)) u_dutB (
        .iClk(iClk), .iRst_n(iRst_n), .iB_Tick(bTick), .iRx(rxB),
        .oRx_Data(dataB), .oRx_Valid(validB), .oRx_Busy(busyB),
        .oParity_Err(perrB), .oFrame_Err(ferrB));

    uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dutC (
        .iClk(iClk), .iRst_n(iRst_n), .iB_Tick(bTick), .iRx(rxC),
        .oRx_Data(dataC), .oRx_Valid(validC), .oRx_Busy(busyC),
        .oParity_Err(perrC), .oFrame_Err(ferrC));

    // Clock generator
    always #5 iClk = ~iClk;

    // Oversample tick: one clock wide, every fourth clock
    always @(posedge iClk) begin
        tickDiv <= tickDiv + 2'd1;
        bTick   <= (tickDiv == 2'd3);
    end

    // Record every valid pulse per instance
    always @(negedge iClk) begin
        if (validA) begin
            lastD[0] = {1'b0, dataA}; lastP[0] = perrA; lastF[0] = ferrA;
            cnt[0]++;
        end
        if (validB) begin
            lastD[1] = {1'b0, dataB}; lastP[1] = perrB; lastF[1] = ferrB;
            cnt[1]++;
        end
        if (validC) begin
            lastD[2] = {4'b0, dataC}; lastP[2] = perrC; lastF[2] = ferrC;
            logC[cnt[2] & 7] = dataC;
            cnt[2]++;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic setRx(input int idx, input logic v);
        case (idx)
            0:       rxA = v;
            1:       rxB = v;
            default: rxC = v;
        endcase
    endtask

    task automatic waitBit(input int os);
        repeat (os * 4) @(negedge iClk);
    endtask

    // parBit < 0 means no parity bit on the line
    task automatic sendFrame(input int idx, input logic [8:0] data, input int nBits,
                             input int os, input int parBit, input logic [1:0] stops,
                             input int nStop);
        setRx(idx, 1'b0);
        waitBit(os);
        for (int i = 0; i < nBits; i++) begin
            setRx(idx, data[i]);
            waitBit(os);
        end
        if (parBit >= 0) begin
            setRx(idx, parBit[0]);
            waitBit(os);
        end
        for (int i = 0; i < nStop; i++) begin
            setRx(idx, stops[i]);
            waitBit(os);
        end
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge iClk);
        checkVal("rst_data",  {24'd0, dataA}, 32'h0);
        checkVal("rst_valid", {31'd0, validA}, 32'h0);
        checkVal("rst_busy",  {31'd0, busyA}, 32'h0);
        checkVal("rst_perr",  {31'd0, perrA}, 32'h0);
        checkVal("rst_ferr",  {31'd0, ferrA}, 32'h0);
        iRst_n = 1'b1;
        repeat (10) @(negedge iClk);

        // 8N1 frame 0xA5
        sendFrame(0, 9'h0A5, 8, 16, -1, 2'b11, 1);
        checkVal("a5_cnt",  cnt[0], 1);
        checkVal("a5_data", {23'd0, lastD[0]}, 32'hA5);
        checkVal("a5_perr", {31'd0, lastP[0]}, 32'h0);
        checkVal("a5_ferr", {31'd0, lastF[0]}, 32'h0);
        checkVal("a5_busy", {31'd0, busyA}, 32'h0);

        // Even parity, correct parity bit
        sendFrame(1, 9'h007, 8, 16, 1, 2'b11, 2);
        checkVal("par_ok_cnt",  cnt[1], 1);
        checkVal("par_ok_data", {23'd0, lastD[1]}, 32'h07);
        checkVal("par_ok_perr", {31'd0, lastP[1]}, 32'h0);
        checkVal("par_ok_ferr", {31'd0, lastF[1]}, 32'h0);

        // Even parity, wrong parity bit
        sendFrame(1, 9'h007, 8, 16, 0, 2'b11, 2);
        checkVal("par_bad_cnt",  cnt[1], 2);
        checkVal("par_bad_data", {23'd0, lastD[1]}, 32'h07);
        checkVal("par_bad_perr", {31'd0, lastP[1]}, 32'h1);

        // Second stop bit low, then line held low (break)
        sendFrame(1, 9'h007, 8, 16, 1, 2'b01, 2);
        waitBit(16);
        checkVal("brk_cnt",  cnt[1], 3);
        checkVal("brk_ferr", {31'd0, lastF[1]}, 32'h1);
        checkVal("brk_perr", {31'd0, lastP[1]}, 32'h0);
        repeat (19) waitBit(16);
        setRx(1, 1'b1);
        repeat (3) waitBit(16);
        checkVal("brk_nopulse", cnt[1], 3);
        checkVal("brk_idle",    {31'd0, busyB}, 32'h0);
        sendFrame(1, 9'h0C3, 8, 16, 0, 2'b11, 2);
        checkVal("brk_after_cnt",  cnt[1], 4);
        checkVal("brk_after_data", {23'd0, lastD[1]}, 32'hC3);
        checkVal("brk_after_ferr", {31'd0, lastF[1]}, 32'h0);

        // Start-bit glitch of 4 ticks
        setRx(0, 1'b0);
        repeat (8) @(negedge iClk);
        checkVal("glitch_busy_hi", {31'd0, busyA}, 32'h1);
        repeat (8) @(negedge iClk);
        setRx(0, 1'b1);
        repeat (40) @(negedge iClk);
        checkVal("glitch_busy_lo", {31'd0, busyA}, 32'h0);
        checkVal("glitch_cnt",     cnt[0], 1);
        sendFrame(0, 9'h03C, 8, 16, -1, 2'b11, 1);
        checkVal("3c_cnt",  cnt[0], 2);
        checkVal("3c_data", {23'd0, lastD[0]}, 32'h3C);
        checkVal("3c_ferr", {31'd0, lastF[0]}, 32'h0);

        // 5-bit frames back to back, OVERSAMPLE 8
        sendFrame(2, 9'h01F, 5, 8, -1, 2'b11, 1);
        sendFrame(2, 9'h000, 5, 8, -1, 2'b11, 1);
        sendFrame(2, 9'h015, 5, 8, -1, 2'b11, 1);
        checkVal("b2b_cnt", cnt[2], 3);
        checkVal("b2b_d0",  {27'd0, logC[0]}, 32'h1F);
        checkVal("b2b_d1",  {27'd0, logC[1]}, 32'h00);
        checkVal("b2b_d2",  {27'd0, logC[2]}, 32'h15);
        checkVal("b2b_ferr", {31'd0, lastF[2]}, 32'h0);

        // Reset during the third data bit of 0xFF
        setRx(0, 1'b0);
        waitBit(16);
        setRx(0, 1'b1);
        waitBit(16);
        waitBit(16);
        repeat (32) @(negedge iClk);
        iRst_n = 1'b0;
        @(negedge iClk);
        checkVal("midrst_data", {24'd0, dataA}, 32'h0);
        checkVal("midrst_busy", {31'd0, busyA}, 32'h0);
        repeat (3) @(negedge iClk);
        iRst_n = 1'b1;
        repeat (7) waitBit(16);
        checkVal("midrst_nopulse", cnt[0], 2);
        sendFrame(0, 9'h081, 8, 16, -1, 2'b11, 1);
        checkVal("81_cnt",  cnt[0], 3);
        checkVal("81_data", {23'd0, lastD[0]}, 32'h81);

`ifdef UART_RX_MAJORITY_EN
        // Single-tick inversion near the centre of data bit 3
        begin : b_majority
            logic [7:0] v;
            v = 8'h5A;
            setRx(0, 1'b0);
            waitBit(16);
            for (int i = 0; i < 8; i++) begin
                setRx(0, v[i]);
                if (i == 3) begin
                    repeat (30) @(negedge iClk);
                    setRx(0, ~v[i]);
                    repeat (4) @(negedge iClk);
                    setRx(0, v[i]);
                    repeat (30) @(negedge iClk);
                end else begin
                    waitBit(16);
                end
            end
            setRx(0, 1'b1);
            waitBit(16);
            checkVal("maj_cnt",  cnt[0], 4);
            checkVal("maj_data", {23'd0, lastD[0]}, 32'h5A);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire
